dnn_bank_dual_avalon: RTL

Parametrised on-chip weight/activation bank for the DNN accelerator system. It has two Avalon-MM slave ports: `s1` for the CPU/loader and `s2` for the accelerator datapath. Both ports share one single-port storage array through a round-robin arbiter, with pipelined reads, `readdatavalid` and `waitrequest` flow control. It replaces fixed 1024x32 single-port banks wherever the CPU and the accelerator must both reach the same bank.

---
 rtl/dnn_bank_dual_avalon.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dnn_bank_dual_avalon.sv
// dnn_bank_dual_avalon: two Avalon-MM slaves sharing one single-port array through a round-robin arbiter.
// Optional DNN_BANK_CLEAR_EN: zero-sweep the array after reset before accepting traffic.
module dnn_bank_dual_avalon #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic                    s1_waitrequest,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic                    s2_waitrequest,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    init_done
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  busy, last_grant, req1, req2, grant1, grant2;
    logic                  wr_acc, rd_acc, clr_we, src_vld, src_tag;
    logic [ADDR_WIDTH-1:0] addr, clr_addr;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata, rd_word, src_data;

    // last_grant=1 means s2 won last, so s1 takes the next tie
    always_comb begin
        req1    = s1_read | s1_write;
        req2    = s2_read | s2_write;
        grant1  = ~busy & ~reset & req1 & (~req2 | last_grant);
        grant2  = ~busy & ~reset & req2 & ~grant1;
        addr    = grant1 ? s1_address : s2_address;
        be      = grant1 ? s1_byteenable : s2_byteenable;
        wdata   = grant1 ? s1_writedata : s2_writedata;
        wr_acc  = grant1 ? s1_write : grant2 & s2_write;
        rd_acc  = grant1 ? s1_read & ~s1_write : grant2 & s2_read & ~s2_write;
        rd_word = mem[addr];
    end

    assign s1_waitrequest = req1 & ~grant1;
    assign s2_waitrequest = req2 & ~grant2;
    assign init_done      = ~busy;

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (grant1 | grant2)
            last_grant <= grant2;
    end

`ifdef DNN_BANK_CLEAR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b1;
            clr_addr <= '0;
        end else if (busy) begin
            clr_addr <= clr_addr + 1'b1;
            busy     <= ~&clr_addr;
        end
    end
    assign clr_we = busy;
`else
    always_ff @(posedge clk) begin
        busy <= reset;
    end
    assign clr_addr = '0;
    assign clr_we   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (wr_acc)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

    // src_* is the last pipeline stage before the per-port output registers
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  a_vld, a_tag;
            logic [DATA_WIDTH-1:0] a_data;
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_vld <= 1'b0;
                    a_tag <= 1'b0;
                end else begin
                    a_vld <= rd_acc;
                    a_tag <= grant2;
                end
                a_data <= rd_word;
            end
            assign src_vld  = a_vld;
            assign src_tag  = a_tag;
            assign src_data = a_data;
        end else begin : g_lat1
            assign src_vld  = rd_acc;
            assign src_tag  = grant2;
            assign src_data = rd_word;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_readdatavalid <= 1'b0;
            s2_readdatavalid <= 1'b0;
            s1_readdata      <= '0;
            s2_readdata      <= '0;
        end else begin
            s1_readdatavalid <= src_vld & ~src_tag;
            s2_readdatavalid <= src_vld & src_tag;
            if (src_vld & ~src_tag) s1_readdata <= src_data;
            if (src_vld & src_tag) s2_readdata <= src_data;
        end
    end
endmodule
